// File: rtl/wb_nic_pkg.sv
// wb_nic_pkg: shared types and constants for the Wishbone slave-select interconnect.
//   nic_state_t          transaction FSM encoding
//   NIC_SLAVE_SEL_WIDTH  default number of decoded top address bits
//   NIC_TIMEOUT          default watchdog limit in BUSY cycles
//   SLV_*                slave index map
package wb_nic_pkg;

    typedef enum logic [1:0] {NIC_IDLE, NIC_BUSY, NIC_ERR} nic_state_t;

    localparam int NIC_SLAVE_SEL_WIDTH = 4;
    localparam int NIC_TIMEOUT         = 255;

    localparam int SLV_TCM  = 0;
    localparam int SLV_UART = 1;
    localparam int SLV_I2C  = 2;
    localparam int SLV_CCM  = 3;

endpackage

// File: rtl/wb_nic_watchdog.sv
// wb_nic_watchdog: per-transaction cycle counter that flags the last allowed BUSY cycle.
//   i_clk, i_reset  clock, asynchronous active-high reset
//   i_run           count this cycle (transaction in progress)
//   i_clr           return the counter to zero at the next edge (takes priority)
//   o_expired       counter has reached TIMEOUT-1 while running
module wb_nic_watchdog
    import wb_nic_pkg::*;
#(
    parameter int TIMEOUT = NIC_TIMEOUT
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_run,
    input  logic i_clr,
    output logic o_expired
);

    localparam int TO_WIDTH = $clog2(TIMEOUT + 1);

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    always_comb cnt_d = i_clr ? '0 : i_run ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) cnt_q <= '0;
        else         cnt_q <= cnt_d;

    assign o_expired = i_run && cnt_q == TO_WIDTH'(TIMEOUT - 1);

endmodule

// File: rtl/wb_nic_wdt.sv
// wb_nic_wdt: registered Wishbone slave select with unmapped-error, timeout watchdog and sticky error record.
//   i_clk, i_reset                       clock, asynchronous active-high reset
//   i_wb_adr/we/stb/cyc                  single master request
//   o_wb_dat/ack/err                     master response
//   o_slave_sel                          one-hot select, valid only while a transfer is in flight
//   i_slave_rdata, i_slave_ack           packed per-slave read data and acks
//   i_err_clr                            clears the sticky error record
//   o_err_valid/addr/timeout             first recorded error since last clear
module wb_nic_wdt
    import wb_nic_pkg::*;
#(
    parameter int                             ADDR_SEL_WIDTH = NIC_SLAVE_SEL_WIDTH,
    parameter int                             DATA_WIDTH     = 32,
    parameter logic [2**ADDR_SEL_WIDTH-1:0]   SLAVE_MASK     = 'h0003,
    parameter int                             TIMEOUT        = NIC_TIMEOUT
) (
    input  logic                                      i_clk,
    input  logic                                      i_reset,
    input  logic [31:0]                               i_wb_adr,
    input  logic                                      i_wb_we,
    input  logic                                      i_wb_stb,
    input  logic                                      i_wb_cyc,
    output logic [DATA_WIDTH-1:0]                     o_wb_dat,
    output logic                                      o_wb_ack,
    output logic                                      o_wb_err,
    output logic [2**ADDR_SEL_WIDTH-1:0]              o_slave_sel,
    input  logic [2**ADDR_SEL_WIDTH*DATA_WIDTH-1:0]   i_slave_rdata,
    input  logic [2**ADDR_SEL_WIDTH-1:0]              i_slave_ack,
    input  logic                                      i_err_clr,
    output logic                                      o_err_valid,
    output logic [31:0]                               o_err_addr,
    output logic                                      o_err_timeout
);

    localparam int N_SLAVES = 2**ADDR_SEL_WIDTH;

    nic_state_t                state_q, state_d;
    logic [ADDR_SEL_WIDTH-1:0] idx_q, idx_d, idx;
    logic [31:0]               adr_q, adr_d, err_addr_q, err_addr_d;
    logic                      err_valid_q, err_valid_d, err_timeout_q, err_timeout_d;
    logic                      busy, hit, expired, req, unused;

    // Write enable does not influence decoding.
    assign unused = i_wb_we;

    assign idx  = i_wb_adr[31 -: ADDR_SEL_WIDTH];
    assign req  = i_wb_cyc & i_wb_stb;
    assign busy = state_q == NIC_BUSY;
    // Gating with cyc keeps an abandoned transfer from completing.
    assign hit  = busy & i_wb_cyc & i_slave_ack[idx_q];

    // Counter is held at zero whenever the next cycle is not BUSY.
    wb_nic_watchdog #(.TIMEOUT(TIMEOUT)) u_wdt (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_run     (busy),
        .i_clr     (state_d != NIC_BUSY),
        .o_expired (expired)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        adr_d   = adr_q;
        case (state_q)
            NIC_IDLE: if (req) begin
                idx_d   = idx;
                adr_d   = i_wb_adr;
                state_d = SLAVE_MASK[idx] ? NIC_BUSY : NIC_ERR;
            end
            NIC_BUSY: state_d = (!i_wb_cyc || hit) ? NIC_IDLE : expired ? NIC_ERR : NIC_BUSY;
            default:  state_d = NIC_IDLE;
        endcase
    end

    // A clear coinciding with a new error lets the new error be recorded.
    always_comb begin
        err_valid_d   = err_valid_q;
        err_addr_d    = err_addr_q;
        err_timeout_d = err_timeout_q;
        if (state_d == NIC_ERR && (!err_valid_q || i_err_clr)) begin
            err_valid_d   = 1'b1;
            err_addr_d    = busy ? adr_q : i_wb_adr;
            err_timeout_d = busy;
        end else if (i_err_clr) begin
            err_valid_d   = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) begin
            state_q       <= NIC_IDLE;
            idx_q         <= '0;
            adr_q         <= '0;
            err_valid_q   <= 1'b0;
            err_addr_q    <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            adr_q         <= adr_d;
            err_valid_q   <= err_valid_d;
            err_addr_q    <= err_addr_d;
            err_timeout_q <= err_timeout_d;
        end

    assign o_slave_sel   = busy ? N_SLAVES'(1) << idx_q : '0;
    assign o_wb_ack      = hit;
    assign o_wb_dat      = hit ? i_slave_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign o_wb_err      = state_q == NIC_ERR;
    assign o_err_valid   = err_valid_q;
    assign o_err_addr    = err_addr_q;
    assign o_err_timeout = err_timeout_q;

endmodule
